// File: rtl/time_set_pkg.sv
// Shared definitions for the time-setting controller: position codes,
// controller states and default field limits.
package time_set_pkg;

   // Encodings of the position selector input
   localparam logic [1:0] POS_SEC  = 2'b00;
   localparam logic [1:0] POS_MIN  = 2'b01;
   localparam logic [1:0] POS_HOUR = 2'b10;
   localparam logic [1:0] POS_NONE = 2'b11;

   // Controller states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SET    = 2'b01,
      COMMIT = 2'b10
   } state_e;

   // Default limits and timing
   localparam int HOUR_MAX_DEF     = 23;
   localparam int MIN_MAX_DEF      = 59;
   localparam int SEC_MAX_DEF      = 59;
   localparam int REPEAT_DELAY_DEF = 50_000_000;
   localparam int REPEAT_RATE_DEF  = 10_000_000;
   localparam int FIELD_W_DEF      = 8;

   // Larger of two integers, used to size the shared repeat counter
   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/field_counter.sv
// One editable time field: loadable, wraps to 0 above MAX and to MAX below 0.
// A load value above MAX is clamped so the field never leaves its range.
module field_counter #(
   parameter int MAX = 59,
   parameter int W   = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_en,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] MAX_V  = W'(MAX);
   localparam logic [W-1:0] ZERO_V = {W{1'b0}};
   localparam logic [W-1:0] ONE_V  = W'(1);

   logic [W-1:0] value_r;
   logic [W-1:0] value_next_s;

   // Next field value: load has priority, then a single-direction step
   always_comb begin
      value_next_s = value_r;
      if (load_en) begin
         if (load_val > MAX_V) begin
            value_next_s = MAX_V;
         end else begin
            value_next_s = load_val;
         end
      end else if (inc && !dec) begin
         if (value_r >= MAX_V) begin
            value_next_s = ZERO_V;
         end else begin
            value_next_s = value_r + ONE_V;
         end
      end else if (dec && !inc) begin
         if (value_r == ZERO_V) begin
            value_next_s = MAX_V;
         end else if (value_r > MAX_V) begin
            value_next_s = MAX_V;
         end else begin
            value_next_s = value_r - ONE_V;
         end
      end else begin
         value_next_s = value_r;
      end
   end

   // Field register
   always_ff @(posedge clk) begin
      if (reset) begin
         value_r <= ZERO_V;
      end else begin
         value_r <= value_next_s;
      end
   end

   assign value = value_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day setting controller. Captures the running time on entry to set
// mode, lets the user step the selected field with add/sub buttons (with
// hold-to-repeat) and pulses load for one cycle when set mode is left.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int HOUR_MAX     = HOUR_MAX_DEF,
   parameter int MIN_MAX      = MIN_MAX_DEF,
   parameter int SEC_MAX      = SEC_MAX_DEF,
   parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
   parameter int FIELD_W      = FIELD_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               activation,
   input  logic [1:0]         position,
   input  logic               add_press,
   input  logic               sub_press,
   input  logic [FIELD_W-1:0] cur_hours,
   input  logic [FIELD_W-1:0] cur_minutes,
   input  logic [FIELD_W-1:0] cur_seconds,
   output logic [FIELD_W-1:0] hours,
   output logic [FIELD_W-1:0] minutes,
   output logic [FIELD_W-1:0] seconds,
   output logic               setting,
   output logic               load
);

   // Repeat counter must hold both the initial delay and the repeat period
   localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_e           state_r;
   state_e           state_next_s;

   logic             act_prev_r;
   logic             add_prev_r;
   logic             sub_prev_r;
   logic [1:0]       pos_prev_r;

   logic [CNT_W-1:0] rpt_cnt_r;
   logic             rpt_active_r;
   logic             hold_prev_r;

   logic             setting_r;
   logic             load_r;

   logic             act_rise_s;
   logic             act_fall_s;
   logic             add_rise_s;
   logic             sub_rise_s;
   logic             single_add_s;
   logic             single_sub_s;
   logic             in_set_s;
   logic             hold_s;
   logic             pos_chg_s;
   logic             restart_s;
   logic             rpt_tick_s;
   logic             edge_step_s;
   logic             step_s;
   logic             inc_s;
   logic             dec_s;
   logic             capture_s;

   logic             sec_inc_s;
   logic             sec_dec_s;
   logic             min_inc_s;
   logic             min_dec_s;
   logic             hour_inc_s;
   logic             hour_dec_s;

   // Edge detection and step qualification
   assign act_rise_s   = activation & ~act_prev_r;
   assign act_fall_s   = ~activation & act_prev_r;
   assign add_rise_s   = add_press & ~add_prev_r;
   assign sub_rise_s   = sub_press & ~sub_prev_r;
   assign single_add_s = add_press & ~sub_press;
   assign single_sub_s = sub_press & ~add_press;
   assign in_set_s     = (state_r == SET);
   // Exactly one button held while editing; both held keeps repeat in reset
   assign hold_s       = in_set_s & (single_add_s | single_sub_s);
   assign pos_chg_s    = (position != pos_prev_r);
   // A fresh press, a direction swap, a new field or a gap restarts the delay
   assign restart_s    = add_rise_s | sub_rise_s | ~hold_prev_r | pos_chg_s;
   assign edge_step_s  = (single_add_s & add_rise_s) | (single_sub_s & sub_rise_s);
   assign step_s       = hold_s & (edge_step_s | rpt_tick_s);
   assign inc_s        = step_s & single_add_s;
   assign dec_s        = step_s & single_sub_s;
   assign capture_s    = (state_r == IDLE) & act_rise_s;

   // Input history used for edge detection and position-change detection
   always_ff @(posedge clk) begin
      if (reset) begin
         act_prev_r <= 1'b0;
         add_prev_r <= 1'b0;
         sub_prev_r <= 1'b0;
         pos_prev_r <= POS_SEC;
      end else begin
         act_prev_r <= activation;
         add_prev_r <= add_press;
         sub_prev_r <= sub_press;
         pos_prev_r <= position;
      end
   end

   // Auto-repeat tick: counter reached the end of the delay or repeat period
   always_comb begin
      rpt_tick_s = 1'b0;
      if (hold_s && !restart_s) begin
         if (rpt_active_r) begin
            rpt_tick_s = (rpt_cnt_r == RATE_LAST);
         end else begin
            rpt_tick_s = (rpt_cnt_r == DELAY_LAST);
         end
      end else begin
         rpt_tick_s = 1'b0;
      end
   end

   // Hold-duration counter: delay phase first, then fixed-rate repeat phase
   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_cnt_r    <= CNT_ZERO;
         rpt_active_r <= 1'b0;
         hold_prev_r  <= 1'b0;
      end else if (!hold_s) begin
         rpt_cnt_r    <= CNT_ZERO;
         rpt_active_r <= 1'b0;
         hold_prev_r  <= 1'b0;
      end else if (restart_s) begin
         rpt_cnt_r    <= CNT_ZERO;
         rpt_active_r <= 1'b0;
         hold_prev_r  <= 1'b1;
      end else if (rpt_tick_s) begin
         rpt_cnt_r    <= CNT_ZERO;
         rpt_active_r <= 1'b1;
         hold_prev_r  <= 1'b1;
      end else begin
         rpt_cnt_r    <= rpt_cnt_r + CNT_ONE;
         rpt_active_r <= rpt_active_r;
         hold_prev_r  <= 1'b1;
      end
   end

   // Route the step to the field chosen by position
   always_comb begin
      sec_inc_s  = 1'b0;
      sec_dec_s  = 1'b0;
      min_inc_s  = 1'b0;
      min_dec_s  = 1'b0;
      hour_inc_s = 1'b0;
      hour_dec_s = 1'b0;
      case (position)
         POS_SEC: begin
            sec_inc_s = inc_s;
            sec_dec_s = dec_s;
         end
         POS_MIN: begin
            min_inc_s = inc_s;
            min_dec_s = dec_s;
         end
         POS_HOUR: begin
            hour_inc_s = inc_s;
            hour_dec_s = dec_s;
         end
         POS_NONE: begin
            sec_inc_s = 1'b0;
         end
         default: begin
            sec_inc_s = 1'b0;
         end
      endcase
   end

   // Mode sequencing: idle, editing, one-cycle commit
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (act_rise_s) begin
               state_next_s = SET;
            end else begin
               state_next_s = IDLE;
            end
         end
         SET: begin
            if (act_fall_s) begin
               state_next_s = COMMIT;
            end else begin
               state_next_s = SET;
            end
         end
         COMMIT: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register plus registered mode flags derived from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         setting_r <= 1'b0;
         load_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         setting_r <= (state_next_s == SET);
         load_r    <= (state_next_s == COMMIT);
      end
   end

   field_counter #(
      .MAX (SEC_MAX),
      .W   (FIELD_W)
   ) u_sec (
      .clk      (clk),
      .reset    (reset),
      .load_en  (capture_s),
      .load_val (cur_seconds),
      .inc      (sec_inc_s),
      .dec      (sec_dec_s),
      .value    (seconds)
   );

   field_counter #(
      .MAX (MIN_MAX),
      .W   (FIELD_W)
   ) u_min (
      .clk      (clk),
      .reset    (reset),
      .load_en  (capture_s),
      .load_val (cur_minutes),
      .inc      (min_inc_s),
      .dec      (min_dec_s),
      .value    (minutes)
   );

   field_counter #(
      .MAX (HOUR_MAX),
      .W   (FIELD_W)
   ) u_hour (
      .clk      (clk),
      .reset    (reset),
      .load_en  (capture_s),
      .load_val (cur_hours),
      .inc      (hour_inc_s),
      .dec      (hour_dec_s),
      .value    (hours)
   );

   assign setting = setting_r;
   assign load    = load_r;

endmodule
